// File: rtl/eb_pkg.sv
// rtl/eb_pkg.sv - shared types, constants and the SKP match helper for the elastic buffer
package eb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } eb_rd_state_e;

   localparam int ERR_OVF_BIT = 0;
   localparam int ERR_UDF_BIT = 1;
   localparam int CNT_W       = 16;

   // Callers zero-extend to this width, so any symbol width up to 64 bits fits.
   localparam int SKP_MAX_W   = 64;

   function automatic logic is_skp(input logic [SKP_MAX_W-1:0] data,
                                   input logic [SKP_MAX_W-1:0] seq1,
                                   input logic [SKP_MAX_W-1:0] seq2);
      return (data == seq1) || (data == seq2);
   endfunction

endpackage

// File: rtl/eb_sync_ram.sv
// rtl/eb_sync_ram.sv - single-clock storage array, one synchronous write port and one asynchronous read port
module eb_sync_ram #(
   parameter int DATA_WIDTH = 20,
   parameter int FIFO_DEPTH = 32,
   localparam int ADDR_W    = $clog2(FIFO_DEPTH)
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/skp_sync_elastic_buffer.sv
// rtl/skp_sync_elastic_buffer.sv - single-clock elastic buffer with SKP drop/insert rate compensation
// Optional pass-through mode enabled by defining EB_BYPASS_EN (adds cfg_bypass_i).
module skp_sync_elastic_buffer
   import eb_pkg::*;
#(
   parameter int DATA_WIDTH = 20,
   parameter int FIFO_DEPTH = 32,
   localparam int FILL_W    = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  sys_clk_i,
   input  logic                  sys_arst_n_i,
`ifdef EB_BYPASS_EN
   input  logic                  cfg_bypass_i,
`endif
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  wr_vld_i,
   input  logic                  rd_rdy_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_vld_o,
   input  logic [FILL_W-1:0]     cfg_cor_max_i,
   input  logic [FILL_W-1:0]     cfg_cor_min_i,
   input  logic [DATA_WIDTH-1:0] cfg_cor_seq_val_1_i,
   input  logic [DATA_WIDTH-1:0] cfg_cor_seq_val_2_i,
   input  logic                  cfg_clr_i,
   output logic [FILL_W-1:0]     stat_fill_level_o,
   output logic [CNT_W-1:0]      stat_cnt_add_o,
   output logic [CNT_W-1:0]      stat_cnt_drop_o,
   output logic                  skp_add_evt_pulse_o,
   output logic                  skp_drop_evt_pulse_o,
   output logic [1:0]            err_status_o
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam logic [FILL_W-1:0] FULL_LVL = FILL_W'(FIFO_DEPTH);

   eb_rd_state_e          state, state_nxt;
   logic [FILL_W-1:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [FILL_W-1:0]     fill, fill_nxt;
   logic [DATA_WIDTH-1:0] head;
   logic                  wr_skp, head_skp, bypass;
   logic                  do_drop, do_ovf, do_store;
   logic                  do_pop, do_ins, do_udf;

`ifdef EB_BYPASS_EN
   assign bypass = cfg_bypass_i;
`else
   assign bypass = 1'b0;
`endif

   assign fill     = wr_ptr - rd_ptr;
   assign wr_skp   = is_skp(SKP_MAX_W'(wr_data_i), SKP_MAX_W'(cfg_cor_seq_val_1_i),
                            SKP_MAX_W'(cfg_cor_seq_val_2_i));
   assign head_skp = is_skp(SKP_MAX_W'(head), SKP_MAX_W'(cfg_cor_seq_val_1_i),
                            SKP_MAX_W'(cfg_cor_seq_val_2_i));

   eb_sync_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_ram (
      .clk     (sys_clk_i),
      .wr_en   (do_store),
      .wr_addr (wr_ptr[ADDR_W-1:0]),
      .wr_data (wr_data_i),
      .rd_addr (rd_ptr[ADDR_W-1:0]),
      .rd_data (head)
   );

   // Read side resolved first: overflow only fires when no pop frees a slot this cycle.
   always_comb begin
      do_udf    = 1'b0;
      do_ins    = 1'b0;
      do_pop    = 1'b0;
      do_drop   = 1'b0;
      do_ovf    = 1'b0;
      do_store  = 1'b0;
      state_nxt = state;
      if (bypass) begin
         state_nxt = IDLE;
      end else begin
         if (state == IDLE) begin
            if (fill >= cfg_cor_min_i) begin
               state_nxt = RUN;
            end
         end else if (rd_rdy_i) begin
            if (fill == '0) begin
               do_udf    = 1'b1;
               state_nxt = IDLE;
            end else if (head_skp && (fill < cfg_cor_min_i)) begin
               do_ins = 1'b1;
            end else begin
               do_pop = 1'b1;
            end
         end
         if (wr_vld_i) begin
            if (wr_skp && (fill > cfg_cor_max_i)) begin
               do_drop = 1'b1;
            end else if ((fill == FULL_LVL) && !do_pop) begin
               do_ovf = 1'b1;
            end else begin
               do_store = 1'b1;
            end
         end
      end
   end

   always_comb begin
      wr_ptr_nxt = wr_ptr + {{(FILL_W-1){1'b0}}, do_store};
      rd_ptr_nxt = rd_ptr + {{(FILL_W-1){1'b0}}, do_pop};
      if (bypass) begin
         wr_ptr_nxt = '0;
         rd_ptr_nxt = '0;
      end
      fill_nxt = wr_ptr_nxt - rd_ptr_nxt;
   end

   always_ff @(posedge sys_clk_i or negedge sys_arst_n_i) begin
      if (!sys_arst_n_i) begin
         state                <= IDLE;
         wr_ptr               <= '0;
         rd_ptr               <= '0;
         rd_data_o            <= '0;
         rd_vld_o             <= 1'b0;
         stat_fill_level_o    <= '0;
         stat_cnt_add_o       <= '0;
         stat_cnt_drop_o      <= '0;
         skp_add_evt_pulse_o  <= 1'b0;
         skp_drop_evt_pulse_o <= 1'b0;
         err_status_o         <= '0;
      end else begin
         state                <= state_nxt;
         wr_ptr               <= wr_ptr_nxt;
         rd_ptr               <= rd_ptr_nxt;
         stat_fill_level_o    <= fill_nxt;
         skp_add_evt_pulse_o  <= do_ins;
         skp_drop_evt_pulse_o <= do_drop;
         if (bypass) begin
            rd_data_o <= wr_data_i;
            rd_vld_o  <= wr_vld_i;
         end else begin
            if (do_pop || do_ins) begin
               rd_data_o <= head;
            end
            rd_vld_o <= do_pop || do_ins;
         end
         if (cfg_clr_i) begin
            stat_cnt_add_o  <= '0;
            stat_cnt_drop_o <= '0;
            err_status_o    <= '0;
         end else begin
            if (do_ins && (stat_cnt_add_o != {CNT_W{1'b1}})) begin
               stat_cnt_add_o <= stat_cnt_add_o + 1'b1;
            end
            if (do_drop && (stat_cnt_drop_o != {CNT_W{1'b1}})) begin
               stat_cnt_drop_o <= stat_cnt_drop_o + 1'b1;
            end
            err_status_o[ERR_OVF_BIT] <= err_status_o[ERR_OVF_BIT] | do_ovf;
            err_status_o[ERR_UDF_BIT] <= err_status_o[ERR_UDF_BIT] | do_udf;
         end
      end
   end

endmodule

// File: tb/tb_skp_sync_elastic_buffer.sv
// tb/tb_skp_sync_elastic_buffer.sv - directed self-checking bench for skp_sync_elastic_buffer
module tb_skp_sync_elastic_buffer;

   localparam int DW    = 20;
   localparam int DEPTH = 16;
   localparam int FW    = 5;
   localparam logic [DW-1:0] SEQ1 = 20'h0F0F0;
   localparam logic [DW-1:0] SEQ2 = 20'hF0F0F;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_vld = 1'b0;
   logic          rd_rdy = 1'b0;
   logic          clr = 1'b0;
   logic [FW-1:0] cor_max = 5'd12;
   logic [FW-1:0] cor_min = 5'd4;
   logic [DW-1:0] seq1 = SEQ1;
   logic [DW-1:0] seq2 = SEQ2;
   logic [DW-1:0] rd_data;
   logic          rd_vld;
   logic [FW-1:0] fill_lvl;
   logic [15:0]   cnt_add, cnt_drop;
   logic          add_pulse, drop_pulse;
   logic [1:0]    err;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   skp_sync_elastic_buffer #(
      .DATA_WIDTH (DW),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .sys_clk_i            (clk),
      .sys_arst_n_i         (rst_n),
      .wr_data_i            (wr_data),
      .wr_vld_i             (wr_vld),
      .rd_rdy_i             (rd_rdy),
      .rd_data_o            (rd_data),
      .rd_vld_o             (rd_vld),
      .cfg_cor_max_i        (cor_max),
      .cfg_cor_min_i        (cor_min),
      .cfg_cor_seq_val_1_i  (seq1),
      .cfg_cor_seq_val_2_i  (seq2),
      .cfg_clr_i            (clr),
      .stat_fill_level_o    (fill_lvl),
      .stat_cnt_add_o       (cnt_add),
      .stat_cnt_drop_o      (cnt_drop),
      .skp_add_evt_pulse_o  (add_pulse),
      .skp_drop_evt_pulse_o (drop_pulse),
      .err_status_o         (err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 ns after the edge; outputs are sampled 1 ns after the consuming edge.
   task automatic cyc(input logic wv, input logic [DW-1:0] wd, input logic rr);
      wr_vld  = wv;
      wr_data = wd;
      rd_rdy  = rr;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      wr_vld = 1'b0;
      rd_rdy = 1'b0;
      clr    = 1'b0;
      rst_n  = 1'b0;
      #12;
      chk("rst_vld",   32'(rd_vld), 32'd0);
      chk("rst_data",  32'(rd_data), 32'd0);
      chk("rst_fill",  32'(fill_lvl), 32'd0);
      chk("rst_add",   32'(cnt_add), 32'd0);
      chk("rst_drop",  32'(cnt_drop), 32'd0);
      chk("rst_pulse", 32'({add_pulse, drop_pulse}), 32'd0);
      chk("rst_err",   32'(err), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   logic [DW-1:0] exp_d;

   initial begin
      do_reset();

      // Startup with rd_rdy high from the start, then drain into underflow.
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b1, DW'(i), 1'b1);
         chk("start_idle_vld", 32'(rd_vld), 32'd0);
      end
      chk("start_fill4", 32'(fill_lvl), 32'd4);
      cyc(1'b1, DW'(5), 1'b1);
      chk("start_enter_run_vld", 32'(rd_vld), 32'd0);
      cyc(1'b1, DW'(6), 1'b1);
      chk("start_first_vld", 32'(rd_vld), 32'd1);
      chk("start_first_data", 32'(rd_data), 32'd1);
      for (int i = 2; i <= 6; i++) begin
         cyc(1'b0, '0, 1'b1);
         chk("start_vld", 32'(rd_vld), 32'd1);
         chk("start_data", 32'(rd_data), 32'(i));
      end
      chk("start_err", 32'(err), 32'd0);
      chk("start_fill0", 32'(fill_lvl), 32'd0);
      cyc(1'b0, '0, 1'b1);
      chk("udf_vld", 32'(rd_vld), 32'd0);
      chk("udf_err", 32'(err), 32'd2);
      for (int i = 7; i <= 11; i++) begin
         cyc(1'b1, DW'(i), 1'b1);
         chk("recenter_vld", 32'(rd_vld), 32'd0);
      end
      cyc(1'b1, DW'(12), 1'b1);
      chk("resume_vld", 32'(rd_vld), 32'd1);
      chk("resume_data", 32'(rd_data), 32'd7);

      do_reset();

      // Fill to 12, SKP at fill 12 is stored, SKP at fill 13 is dropped.
      for (int i = 0; i < 12; i++) cyc(1'b1, DW'(32'h100 + i), 1'b0);
      chk("drop_fill12", 32'(fill_lvl), 32'd12);
      cyc(1'b1, SEQ1, 1'b0);
      chk("nodrop_fill", 32'(fill_lvl), 32'd13);
      chk("nodrop_pulse", 32'(drop_pulse), 32'd0);
      chk("nodrop_cnt", 32'(cnt_drop), 32'd0);
      cyc(1'b1, SEQ2, 1'b0);
      chk("drop_fill", 32'(fill_lvl), 32'd13);
      chk("drop_pulse", 32'(drop_pulse), 32'd1);
      chk("drop_cnt", 32'(cnt_drop), 32'd1);
      cyc(1'b0, '0, 1'b0);
      chk("drop_pulse_end", 32'(drop_pulse), 32'd0);

      // Drive the drop counter to saturation.
      for (int n = 0; n < 65534; n++) cyc(1'b1, SEQ1, 1'b0);
      chk("sat_reach", 32'(cnt_drop), 32'hFFFF);
      cyc(1'b1, SEQ2, 1'b0);
      chk("sat_hold", 32'(cnt_drop), 32'hFFFF);
      chk("sat_pulse", 32'(drop_pulse), 32'd1);
      chk("sat_fill", 32'(fill_lvl), 32'd13);

      // Overflow: three more fill the buffer, the next is discarded.
      for (int i = 0; i < 3; i++) cyc(1'b1, DW'(32'h200 + i), 1'b0);
      chk("full_fill", 32'(fill_lvl), 32'd16);
      chk("full_err", 32'(err), 32'd0);
      cyc(1'b1, DW'(32'h2FF), 1'b0);
      chk("ovf_err", 32'(err), 32'd1);
      chk("ovf_fill", 32'(fill_lvl), 32'd16);

      clr = 1'b1;
      cyc(1'b0, '0, 1'b0);
      clr = 1'b0;
      chk("clr_drop", 32'(cnt_drop), 32'd0);
      chk("clr_err", 32'(err), 32'd0);
      chk("clr_fill", 32'(fill_lvl), 32'd16);

      // Drain: order preserved, stored SKP passes through at fill 4.
      for (int k = 0; k < 16; k++) begin
         if (k < 12)       exp_d = DW'(32'h100 + k);
         else if (k == 12) exp_d = SEQ1;
         else              exp_d = DW'(32'h200 + k - 13);
         cyc(1'b0, '0, 1'b1);
         chk("drain_vld", 32'(rd_vld), 32'd1);
         chk("drain_data", 32'(rd_data), 32'(exp_d));
      end
      chk("drain_add", 32'(cnt_add), 32'd0);
      cyc(1'b0, '0, 1'b1);
      chk("drain_udf_vld", 32'(rd_vld), 32'd0);
      chk("drain_udf_err", 32'(err), 32'd2);
      chk("drain_udf_fill", 32'(fill_lvl), 32'd0);

      do_reset();

      // Insert: SKP at head with fill 3 is repeated once.
      cyc(1'b1, DW'(32'h301), 1'b0);
      cyc(1'b1, DW'(32'h302), 1'b0);
      cyc(1'b1, SEQ2, 1'b0);
      cyc(1'b1, DW'(32'h303), 1'b0);
      cyc(1'b0, '0, 1'b0);
      chk("ins_pre_vld", 32'(rd_vld), 32'd0);
      cyc(1'b0, '0, 1'b1);
      chk("ins_a", 32'(rd_data), 32'h301);
      chk("ins_a_fill", 32'(fill_lvl), 32'd3);
      cyc(1'b1, DW'(32'h304), 1'b1);
      chk("ins_b", 32'(rd_data), 32'h302);
      cyc(1'b1, DW'(32'h305), 1'b1);
      chk("ins_skp1", 32'(rd_data), 32'(SEQ2));
      chk("ins_skp1_vld", 32'(rd_vld), 32'd1);
      chk("ins_pulse", 32'(add_pulse), 32'd1);
      chk("ins_cnt", 32'(cnt_add), 32'd1);
      chk("ins_fill", 32'(fill_lvl), 32'd4);
      cyc(1'b1, DW'(32'h306), 1'b1);
      chk("ins_skp2", 32'(rd_data), 32'(SEQ2));
      chk("ins_pulse_end", 32'(add_pulse), 32'd0);
      cyc(1'b1, DW'(32'h307), 1'b1);
      chk("ins_c", 32'(rd_data), 32'h303);
      cyc(1'b0, '0, 1'b1);
      chk("ins_e", 32'(rd_data), 32'h304);
      chk("ins_cnt_final", 32'(cnt_add), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
